// File: rtl/ram_pkg.sv
// Shared types and helpers for the self-initialising simple-dual-port RAM.
// Latency: n/a (types and a combinational merge helper only).
// Backpressure: n/a.
package ram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } ram_init_state_t;

    localparam int MAX_RD_LATENCY = 4;

    // Widest word the merge helper handles; callers zero-extend and truncate with casts.
    localparam int MERGE_W = 256;

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0] old_word,
        input logic [MERGE_W-1:0] new_word,
        input logic [MERGE_W-1:0] be,
        input int unsigned        byte_w
    );
        logic [MERGE_W-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MERGE_W; i++) begin
            mask[i[7:0]] = be[8'(i / byte_w)];
        end
        return (old_word & ~mask) | (new_word & mask);
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Valid/data shift pipeline appended after the array read register.
// Latency: STAGES cycles (STAGES=0 is a pass-through).
// Backpressure: none; data stages load only on an incoming valid so the output holds.
module ram_rd_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat
);

    if (STAGES == 0) begin : g_bypass
        assign out_vld = in_vld;
        assign out_dat = in_dat;
    end else begin : g_pipe
        logic [STAGES-1:0] vld_q;
        logic [WIDTH-1:0]  dat_q [STAGES];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= '0;
                for (int s = 0; s < STAGES; s++) dat_q[s] <= '0;
            end else begin
                vld_q[0] <= in_vld;
                if (in_vld) dat_q[0] <= in_dat;
                for (int s = 1; s < STAGES; s++) begin
                    vld_q[s] <= vld_q[s-1];
                    if (vld_q[s-1]) dat_q[s] <= dat_q[s-1];
                end
            end
        end

        assign out_vld = vld_q[STAGES-1];
        assign out_dat = dat_q[STAGES-1];
    end

endmodule

// File: rtl/ram_sdp_init.sv
// Self-initialising simple-dual-port RAM with byte-enable writes and collision flag; RAM_WRITE_FIRST_EN selects write-first reads.
// Latency: read data RD_LATENCY cycles after renable; init walk takes DEPTH cycles.
// Backpressure: none; wenable/renable/clear are dropped while init_busy is high.
module ram_sdp_init
    import ram_pkg::*;
#(
    parameter int               DEPTH      = 32,
    parameter int               WIDTH      = 8,
    parameter int               BYTE_W     = 8,
    parameter int               RD_LATENCY = 1,
    parameter logic [WIDTH-1:0] INIT_VAL   = '0,
    localparam int              AWIDTH     = $clog2(DEPTH),
    localparam int              NBYTES     = WIDTH / BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wenable,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [NBYTES-1:0] wbe,
    input  logic              renable,
    input  logic [AWIDTH-1:0] raddr,
    output logic [WIDTH-1:0]  rdata,
    output logic              rvalid,
    output logic              init_busy,
    output logic              collision
);

    localparam logic [AWIDTH:0]   DEPTH_X   = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

    ram_init_state_t   state, state_nxt;
    logic [AWIDTH-1:0] ptr, ptr_nxt;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic              ready, waddr_ok, raddr_ok, rd_acc, wr_acc, hit;
    logic [NBYTES-1:0] wr_lane;
    logic [AWIDTH-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_word, rd_word, rd_q;
    logic              rv_q;

    assign ready    = (state == ST_READY);
    assign waddr_ok = ({1'b0, waddr} < DEPTH_X);
    assign raddr_ok = ({1'b0, raddr} < DEPTH_X);
    assign rd_acc   = ready & renable;
    assign wr_acc   = ready & wenable & waddr_ok;
    assign hit      = rd_acc & wenable & (|wbe) & (waddr == raddr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            ST_INIT: begin
                ptr_nxt = ptr + 1'b1;
                if (ptr == LAST_ADDR) begin
                    state_nxt = ST_READY;
                    ptr_nxt   = '0;
                end
            end
            ST_READY: begin
                if (clear) begin
                    state_nxt = ST_INIT;
                    ptr_nxt   = '0;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // The init walk owns the write port outright; user writes only land in ST_READY.
    always_comb begin
        init_busy = (state == ST_INIT);
        wr_lane   = '0;
        wr_addr   = waddr;
        wr_word   = wdata;
        if (state == ST_INIT) begin
            wr_lane = '1;
            wr_addr = ptr;
            wr_word = INIT_VAL;
        end else if (wr_acc) begin
            wr_lane = wbe;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NBYTES; b++) begin
            if (wr_lane[b]) mem[wr_addr][b*BYTE_W +: BYTE_W] <= wr_word[b*BYTE_W +: BYTE_W];
        end
    end

    always_comb begin
        rd_word = '0;
        if (raddr_ok) begin
`ifdef RAM_WRITE_FIRST_EN
            if (hit) begin
                rd_word = WIDTH'(byte_merge(MERGE_W'(mem[raddr]), MERGE_W'(wdata),
                                            MERGE_W'(wbe), BYTE_W));
            end else begin
                rd_word = mem[raddr];
            end
`else
            rd_word = mem[raddr];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_q      <= 1'b0;
            rd_q      <= '0;
            collision <= 1'b0;
        end else begin
            rv_q      <= rd_acc;
            collision <= hit;
            if (rd_acc) rd_q <= rd_word;
        end
    end

    ram_rd_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (RD_LATENCY - 1)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (rv_q),
        .in_dat  (rd_q),
        .out_vld (rvalid),
        .out_dat (rdata)
    );

endmodule

// File: tb/tb_ram_sdp_init.sv
// Bench for ram_sdp_init: three configurations share one stimulus stream, each scored against a word-level model.
// Latency: n/a.  Backpressure: n/a.
module tb_ram_sdp_init;

    localparam int       NDUT      = 3;
    localparam int       DEP  [3]  = '{32, 32, 20};
    localparam int       LAT  [3]  = '{1, 3, 2};
    localparam logic [15:0] DMASK [3] = '{16'hFFFF, 16'h00FF, 16'h00FF};

    logic        clk = 1'b0;
    logic        rst, clear, wenable, renable;
    logic [4:0]  waddr, raddr;
    logic [15:0] wdata;
    logic [1:0]  wbe;

    logic [15:0] rdata_a;
    logic [7:0]  rdata_b, rdata_c;
    logic        rvalid_a, rvalid_b, rvalid_c;
    logic        busy_a, busy_b, busy_c;
    logic        coll_a, coll_b, coll_c;

    always #5 clk = ~clk;

    ram_sdp_init #(.DEPTH(32), .WIDTH(16), .BYTE_W(8), .RD_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .wenable(wenable), .waddr(waddr),
        .wdata(wdata), .wbe(wbe), .renable(renable), .raddr(raddr),
        .rdata(rdata_a), .rvalid(rvalid_a), .init_busy(busy_a), .collision(coll_a));

    ram_sdp_init #(.DEPTH(32), .WIDTH(8), .BYTE_W(8), .RD_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .wenable(wenable), .waddr(waddr),
        .wdata(wdata[7:0]), .wbe(wbe[0:0]), .renable(renable), .raddr(raddr),
        .rdata(rdata_b), .rvalid(rvalid_b), .init_busy(busy_b), .collision(coll_b));

    ram_sdp_init #(.DEPTH(20), .WIDTH(8), .BYTE_W(8), .RD_LATENCY(2)) dut_c (
        .clk(clk), .rst(rst), .clear(clear), .wenable(wenable), .waddr(waddr),
        .wdata(wdata[7:0]), .wbe(wbe[0:0]), .renable(renable), .raddr(raddr),
        .rdata(rdata_c), .rvalid(rvalid_c), .init_busy(busy_c), .collision(coll_c));

    // Reference model: word arrays, cycles of init left, and read results scheduled by due cycle.
    logic [15:0] mm [NDUT][32];
    int          busy_left [NDUT];
    logic [16:0] sched [NDUT][8];
    logic [15:0] last_rd [NDUT];
    logic        exp_coll [NDUT];
    int          cyc;
    int          vectors;
    int          miscompares;

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            busy_left[d] = DEP[d];
            last_rd[d]   = 16'h0;
            exp_coll[d]  = 1'b0;
            for (int s = 0; s < 8; s++) sched[d][s] = 17'h0;
        end
    endtask

    task automatic model_edge();
        logic [1:0]  be;
        logic [15:0] m, rd;
        logic        hit;
        for (int d = 0; d < NDUT; d++) begin
            if (!rst) begin
                exp_coll[d] = 1'b0;
                if (busy_left[d] > 0) begin
                    mm[d][DEP[d] - busy_left[d]] = 16'h0;
                    busy_left[d]--;
                end else begin
                    be  = (d == 0) ? wbe : {1'b0, wbe[0]};
                    m   = {{8{be[1]}}, {8{be[0]}}};
                    hit = renable && wenable && (be != 2'b00) && (waddr == raddr);
                    if (renable) begin
                        rd = (int'(raddr) < DEP[d]) ? mm[d][raddr] : 16'h0;
`ifdef RAM_WRITE_FIRST_EN
                        if (hit && int'(raddr) < DEP[d]) rd = (rd & ~m) | (wdata & m);
`endif
                        sched[d][(cyc + LAT[d]) % 8] = {1'b1, rd & DMASK[d]};
                    end
                    if (wenable && int'(waddr) < DEP[d] && be != 2'b00)
                        mm[d][waddr] = ((mm[d][waddr] & ~m) | (wdata & m)) & DMASK[d];
                    if (clear) busy_left[d] = DEP[d];
                    exp_coll[d] = hit;
                end
            end
        end
    endtask

    task automatic sample(input int d, output logic [15:0] r, output logic v, output logic b,
                          output logic c);
        case (d)
            0:       begin r = rdata_a;          v = rvalid_a; b = busy_a; c = coll_a; end
            1:       begin r = {8'h0, rdata_b};  v = rvalid_b; b = busy_b; c = coll_b; end
            default: begin r = {8'h0, rdata_c};  v = rvalid_c; b = busy_c; c = coll_c; end
        endcase
    endtask

    task automatic check_all();
        logic [15:0] r;
        logic        v, b, c, exp_v, exp_b;
        for (int d = 0; d < NDUT; d++) begin
            sample(d, r, v, b, c);
            exp_v = sched[d][cyc % 8][16];
            if (exp_v) last_rd[d] = sched[d][cyc % 8][15:0];
            sched[d][cyc % 8] = 17'h0;
            exp_b = (busy_left[d] != 0);

            vectors++;
            assert (b === exp_b) else begin
                miscompares++;
                $error("FAIL init_busy dut%0d cyc=%0d got=%b exp=%b", d, cyc, b, exp_b);
            end
            vectors++;
            assert (v === exp_v) else begin
                miscompares++;
                $error("FAIL rvalid dut%0d cyc=%0d got=%b exp=%b", d, cyc, v, exp_v);
            end
            vectors++;
            assert (r === last_rd[d]) else begin
                miscompares++;
                $error("FAIL rdata dut%0d cyc=%0d got=%h exp=%h", d, cyc, r, last_rd[d]);
            end
            vectors++;
            assert (c === exp_coll[d]) else begin
                miscompares++;
                $error("FAIL collision dut%0d cyc=%0d got=%b exp=%b", d, cyc, c, exp_coll[d]);
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [15:0] wd,
                         input logic [1:0] be, input logic re, input logic [4:0] ra,
                         input logic clr);
        wenable = we;
        waddr   = wa;
        wdata   = wd;
        wbe     = be;
        renable = re;
        raddr   = ra;
        clear   = clr;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 16'h0, 2'b00, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic rd(input logic [4:0] a);
        drive(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, a, 1'b0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d, input logic [1:0] be);
        drive(1'b1, a, d, be, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rst = 1'b1; clear = 1'b0; wenable = 1'b0; renable = 1'b0;
        waddr = '0; raddr = '0; wdata = '0; wbe = '0;
        for (int d = 0; d < NDUT; d++)
            for (int a = 0; a < 32; a++) mm[d][a] = 16'h0;
        model_reset();

        // Reset state, then the init walk and a full sweep of reads.
        #1;
        check_all();
        step(); step(); step();
        rst = 1'b0;
        idle(32);
        for (int a = 0; a < 32; a++) rd(5'(a));
        idle(4);

        // Write then read back; byte-lane merge; same-address read/write collision.
        wr(5'd3, 16'h5AA5, 2'b11);
        rd(5'd3);
        idle(4);
        wr(5'd5, 16'h1234, 2'b11);
        wr(5'd5, 16'hABCD, 2'b10);
        rd(5'd5);
        idle(4);
        wr(5'd7, 16'h0011, 2'b11);
        drive(1'b1, 5'd7, 16'h0022, 2'b11, 1'b1, 5'd7, 1'b0);
        rd(5'd7);
        idle(4);
        drive(1'b1, 5'd9, 16'h00EE, 2'b00, 1'b1, 5'd9, 1'b0);
        rd(5'd9);
        idle(4);

        // Random traffic, including out-of-range addresses for the 20-deep instance.
        for (int i = 0; i < 500; i++) begin
            logic [4:0] wa;
            wa = 5'($urandom);
            drive(1'($urandom), wa, 16'($urandom), 2'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom),
                  ($urandom_range(0, 99) == 0));
        end

        // Clear restarts init; reads issued during it are dropped.
        idle(40);
        wr(5'd0, 16'hFFFF, 2'b11);
        drive(1'b0, 5'd0, 16'h0, 2'b00, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 32; i++) rd(5'd0);
        idle(4);
        rd(5'd0);
        idle(4);

        // Asynchronous reset with reads in flight.
        wr(5'd1, 16'h0101, 2'b11);
        wr(5'd2, 16'h0202, 2'b11);
        rd(5'd1);
        rd(5'd2);
        rd(5'd3);
        renable = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        step(); step();
        rst = 1'b0;
        idle(40);
        rd(5'd1);
        rd(5'd2);
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
